// File: rtl/clock_mux_pkg.sv
// Shared types and helpers for the break-before-make clock-route controller.
// Covers the FSM state encoding and the channel-index to one-hot decode.
package clock_mux_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        CM_IDLE  = 2'd0,
        CM_ON    = 2'd1,
        CM_DRAIN = 2'd2
    } cm_state_t;

    // Out-of-range indices decode to all-zero so a bad select can never enable a path.
    function automatic logic [MAX_CH-1:0] onehot_idx(input logic [3:0] idx, input logic [4:0] n);
        logic [MAX_CH-1:0] vec;
        vec = {MAX_CH{1'b0}};
        if ({1'b0, idx} < n) begin
            vec[idx] = 1'b1;
        end else begin
            vec = {MAX_CH{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/clock_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input.
// A synchronous reset clears every stage so no stale request survives reset.
module clock_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic sync_reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_r;

    // Shift chain; the first stage is the only one allowed to go metastable.
    always_ff @(posedge clock) begin
        if (sync_reset) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_r[STAGES-1];

endmodule

// File: rtl/clock_route_control_mux_n.sv
// Break-before-make controller driving one ICG enable per clock path.
// Priority arbitration in IDLE, no preemption while ON, fixed all-off drain between paths.
module clock_route_control_mux_n
    import clock_mux_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int OFF_WAIT    = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              sync_reset,
    input  logic [NUM_CH-1:0] async_enable,
    input  logic              async_test_en,
    input  logic [CH_W-1:0]   test_sel,
    output logic [NUM_CH-1:0] control_path_enable,
    output logic [NUM_CH-1:0] async_enable_ack,
    output logic              active_valid,
    output logic [CH_W-1:0]   active_sel,
    output logic              busy
);

    localparam int CNT_W = $clog2(OFF_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(OFF_WAIT - 1);

    logic [NUM_CH-1:0] req_s;
    logic              tst_s;
    logic              win_valid_s;
    logic [CH_W-1:0]   win_idx_s;
    logic              req_cur_s;
    logic [NUM_CH-1:0] test_vec_s;

    cm_state_t         state_r;
    cm_state_t         state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_n_s;
    logic [CH_W-1:0]   cur_r;
    logic [CH_W-1:0]   cur_n_s;

    logic [NUM_CH-1:0] enable_r;
    logic [NUM_CH-1:0] ack_r;
    logic              active_valid_r;
    logic [CH_W-1:0]   active_sel_r;
    logic              busy_r;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req_sync
        clock_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
            .clock      (clock),
            .sync_reset (sync_reset),
            .async_in   (async_enable[gi]),
            .sync_out   (req_s[gi])
        );
    end

    clock_sync_bit #(.STAGES(SYNC_STAGES)) u_tst_sync (
        .clock      (clock),
        .sync_reset (sync_reset),
        .async_in   (async_test_en),
        .sync_out   (tst_s)
    );

    // Lowest requesting index wins; scanning downward leaves the lowest one last.
    always_comb begin
        win_valid_s = |req_s;
        win_idx_s   = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            win_idx_s = req_s[i] ? CH_W'(i) : win_idx_s;
        end
    end

    assign req_cur_s  = req_s[cur_r];
    assign test_vec_s = NUM_CH'(onehot_idx(4'(test_sel), 5'(NUM_CH)));

    // Next-state logic; test mode parks the FSM in DRAIN with a full count so exit honours the gap.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        cur_n_s   = cur_r;
        if (tst_s) begin
            state_n_s = CM_DRAIN;
            cnt_n_s   = CNT_RELOAD;
        end else begin
            case (state_r)
                CM_IDLE: begin
                    if (win_valid_s) begin
                        state_n_s = CM_ON;
                        cur_n_s   = win_idx_s;
                    end else begin
                        state_n_s = CM_IDLE;
                    end
                end
                CM_ON: begin
                    if (!req_cur_s) begin
                        state_n_s = CM_DRAIN;
                        cnt_n_s   = CNT_RELOAD;
                    end else begin
                        state_n_s = CM_ON;
                    end
                end
                CM_DRAIN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_n_s = CM_IDLE;
                    end else begin
                        cnt_n_s = cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_n_s = CM_IDLE;
                    cnt_n_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and registered outputs; ack only follows an enable that was already high last cycle.
    always_ff @(posedge clock) begin
        if (sync_reset) begin
            state_r        <= CM_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            cur_r          <= {CH_W{1'b0}};
            enable_r       <= {NUM_CH{1'b0}};
            ack_r          <= {NUM_CH{1'b0}};
            active_valid_r <= 1'b0;
            active_sel_r   <= {CH_W{1'b0}};
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_n_s;
            cnt_r          <= cnt_n_s;
            cur_r          <= cur_n_s;
            enable_r       <= (state_n_s == CM_ON) ?
                              NUM_CH'(onehot_idx(4'(cur_n_s), 5'(NUM_CH))) : {NUM_CH{1'b0}};
            ack_r          <= (state_r == CM_ON && state_n_s == CM_ON) ? enable_r : {NUM_CH{1'b0}};
            active_valid_r <= (state_n_s == CM_ON);
            active_sel_r   <= (state_n_s == CM_ON) ? cur_n_s : {CH_W{1'b0}};
            busy_r         <= (state_n_s == CM_DRAIN);
        end
    end

    assign control_path_enable = tst_s ? test_vec_s : enable_r;
    assign async_enable_ack    = tst_s ? {NUM_CH{1'b0}} : ack_r;
    assign active_valid        = active_valid_r & ~tst_s;
    assign active_sel          = tst_s ? {CH_W{1'b0}} : active_sel_r;
    assign busy                = busy_r | tst_s;

endmodule

// File: tb/tb_clock_route_control_mux_n.sv
// Self-checking bench: vector table through a scoreboard queue plus hand sequences
// for reset, drain-gap timing and out-of-range test select.
module tb_clock_route_control_mux_n;

    logic       clock = 1'b0;
    logic       sync_reset;
    logic [3:0] async_enable;
    logic       async_test_en;
    logic [1:0] test_sel;
    logic [3:0] en, ack;
    logic       valid, busy;
    logic [1:0] asel;

    logic [2:0] async_enable3;
    logic       test_en3;
    logic [1:0] test_sel3;
    logic [2:0] en3, ack3;
    logic       valid3, busy3;
    logic [1:0] asel3;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    typedef struct {
        logic [3:0] req;
        logic       tst;
        logic [1:0] sel;
        int         w;
        logic [3:0] en;
        logic [3:0] ack;
        logic       valid;
        logic [1:0] asel;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    clock_route_control_mux_n #(.NUM_CH(4), .SYNC_STAGES(2), .OFF_WAIT(4)) dut (
        .clock               (clock),
        .sync_reset          (sync_reset),
        .async_enable        (async_enable),
        .async_test_en       (async_test_en),
        .test_sel            (test_sel),
        .control_path_enable (en),
        .async_enable_ack    (ack),
        .active_valid        (valid),
        .active_sel          (asel),
        .busy                (busy)
    );

    clock_route_control_mux_n #(.NUM_CH(3), .SYNC_STAGES(2), .OFF_WAIT(4)) dut3 (
        .clock               (clock),
        .sync_reset          (sync_reset),
        .async_enable        (async_enable3),
        .async_test_en       (test_en3),
        .test_sel            (test_sel3),
        .control_path_enable (en3),
        .async_enable_ack    (ack3),
        .active_valid        (valid3),
        .active_sel          (asel3),
        .busy                (busy3)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_en, input logic [3:0] e_ack,
                             input logic e_valid, input logic [1:0] e_sel, input logic e_busy);
        check({tag, "_en"},    32'(en),    32'(e_en));
        check({tag, "_ack"},   32'(ack),   32'(e_ack));
        check({tag, "_valid"}, 32'(valid), 32'(e_valid));
        check({tag, "_sel"},   32'(asel),  32'(e_sel));
        check({tag, "_busy"},  32'(busy),  32'(e_busy));
    endtask

    // Invariants every cycle: at most one enable, and no ack without its enable.
    always @(negedge clock) begin
        if (mon_on) begin
            checks++;
            if (!$onehot0(en) || ((ack & ~en) != 4'b0000)) begin
                failures++;
                $display("FAIL invariant en=%b ack=%b", en, ack);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        sync_reset    = 1'b1;
        async_enable  = 4'b1111;
        async_test_en = 1'b0;
        test_sel      = 2'd0;
        async_enable3 = 3'b000;
        test_en3      = 1'b0;
        test_sel3     = 2'd0;

        // Reset with all requests high, then first grant SYNC_STAGES+1 edges after release.
        tick(3);
        mon_on = 1'b1;
        check_all("rst", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        sync_reset = 1'b0;
        tick(2);
        check("rst_rel2_en", 32'(en), 32'h0);
        tick(1);
        check_all("rst_rel3", 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0);
        tick(1);
        check("rst_rel4_ack", 32'(ack), 32'h1);
        async_enable = 4'b0000;
        tick(12);

        //            req      tst   sel   w  en       ack      v     sel   busy
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 2, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 2, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 3, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b1000, 1'b0, 2'd0, 4, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 2'd0, 6, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 2'd0, 3, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0001, 1'b0, 2'd0, 4, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 2'd0, 1, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 2'd0, 1, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 2, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 4, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd0, 2, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0100, 1'b1, 2'd1, 1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0100, 1'b1, 2'd1, 1, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b1, 2'd1, 3, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b1, 2'd3, 1, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd3, 1, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd3, 1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd3, 4, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd3, 1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 2'd3, 1, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 8, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{4'b0101, 1'b0, 2'd0, 3, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 8, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            async_enable  = tbl[i].req;
            async_test_en = tbl[i].tst;
            test_sel      = tbl[i].sel;
            exp_q.push_back(tbl[i]);
            tick(tbl[i].w);
            v = exp_q.pop_front();
            check_all($sformatf("vec%0d", i), v.en, v.ack, v.valid, v.asel, v.busy);
        end

        // Switch 1 -> 3 in one step: count the all-off cycles between the two grants.
        async_enable = 4'b0010;
        tick(4);
        check("sw_start_en", 32'(en), 32'h2);
        async_enable = 4'b1000;
        n = 0;
        while (en != 4'b0000 && n < 10) begin
            tick(1);
            n++;
        end
        check("sw_fall_cycles", 32'(n), 32'd3);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (en != 4'b0000) break;
            n++;
        end
        check("sw_gap_cycles", 32'(n), 32'd5);
        check("sw_new_en", 32'(en), 32'h8);
        tick(1);
        check("sw_new_ack", 32'(ack), 32'h8);

        // Reset mid-ON, then mid-DRAIN.
        sync_reset = 1'b1;
        tick(1);
        check_all("rst_on", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        sync_reset = 1'b0;
        tick(3);
        check("rst_on_regrant", 32'(en), 32'h8);
        async_enable = 4'b0000;
        tick(3);
        check("pre_rst_drain_busy", 32'(busy), 32'h1);
        sync_reset = 1'b1;
        tick(1);
        check_all("rst_drain", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        sync_reset = 1'b0;
        tick(1);
        check("rst_drain_hold_busy", 32'(busy), 32'h0);
        tick(8);

        // Reset beats test mode.
        sync_reset    = 1'b1;
        async_test_en = 1'b1;
        test_sel      = 2'd2;
        tick(3);
        check_all("rst_tst", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        async_test_en = 1'b0;
        tick(1);
        sync_reset = 1'b0;
        tick(4);
        check_all("rst_tst_rel", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Out-of-range test select on a 3-channel instance.
        test_en3  = 1'b1;
        test_sel3 = 2'd1;
        tick(2);
        check("t3_sel1_en", 32'(en3), 32'h2);
        check("t3_busy", 32'(busy3), 32'h1);
        test_sel3 = 2'd3;
        tick(1);
        check("t3_sel3_en", 32'(en3), 32'h0);
        test_sel3 = 2'd2;
        tick(1);
        check("t3_sel2_en", 32'(en3), 32'h4);
        check("t3_ack", 32'(ack3), 32'h0);
        test_en3 = 1'b0;
        tick(8);
        check("t3_exit_en", 32'(en3), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
